switch_mcu_ahb_read_master: RTL and testbench
=============================================

# switch_mcu_ahb_read_master

Single-outstanding AHB read initiator for the switch MCU. It turns a simple valid/ready word-read request into one NONSEQ, single-beat, word-size read on the MCU's AHB bus. It returns the read data or an error as a one-cycle response pulse. It is the initiator end of the bus served by the MCU SRAM responder and uses the same transfer encoding that responder decodes.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles spent in DATA/ERR waiting for in_hready; used only with the timeout macro; must be ≥2.

Ports. One clock; reset is synchronous and active-high.
- in_clk  input  1  clock; all logic on rising edge
- in_rst  input  1  synchronous, active-high reset
- in_req_valid  input  1  read request present
- in_req_addr  input  32  byte address of the word to read
- out_req_ready  output  1  request accepted on an edge where valid&ready
- out_rsp_valid  output  1  one-cycle response pulse; no backpressure
- out_rsp_data  output  32  read data; 0 on error
- out_rsp_err  output  1  response is an error
- out_haddr  output  32  AHB address
- out_hwrite  output  1  always 0
- out_hsize  output  4  constant 4'd2 (word)
- out_hburst  output  3  constant 3'd0 (single)
- out_hport  output  4  constant 4'd3
- out_htrans  output  2  2'd1 = NONSEQ in address phase; 2'd0 = IDLE otherwise
- out_hmastlock  output  1  always 0
- in_hready  input  1  responder ready
- in_hresp  input  1  responder error
- in_hrdata  input  32  responder read data

## Operation
- FSM states:
  - IDLE: out_req_ready=1.
  - ADDR: out_htrans=1, out_haddr=captured address.
  - DATA: out_htrans=0, waiting for the response.
  - ERR: second cycle of a two-cycle error response.
- IDLE, accept with in_req_addr[1:0]==0: register the address into out_haddr, set out_htrans<=1, go to ADDR.
- IDLE, accept with in_req_addr[1:0]!=0: no bus access. Next cycle out_rsp_valid=1, err=1, data=0. Remain in IDLE.
- ADDR:
  - in_hready=1: out_htrans<=0, go to DATA.
  - in_hready=0: hold the address phase; haddr and htrans stay stable.
- DATA:
  - in_hready=1 and in_hresp=0: capture in_hrdata; next cycle rsp_valid=1, err=0. Go to IDLE.
  - in_hready=1 and in_hresp=1: go to IDLE; next cycle rsp_valid=1, err=1, data=0.
  - in_hready=0 and in_hresp=1: go to ERR.
  - in_hready=0 and in_hresp=0: wait.
- ERR:
  - in_hready=1: go to IDLE; next cycle rsp_valid=1, err=1, data=0.
  - in_hready=0: wait.
- out_req_ready = (state==IDLE) & !in_rst. A new request may be accepted in the same cycle that out_rsp_valid is high.
- out_rsp_data and out_rsp_err hold their last value when out_rsp_valid=0. They are sampled only when out_rsp_valid=1.

## Timing
- Reset values: state IDLE; out_haddr=0, out_hwrite=0, out_hsize=4'd2, out_hburst=0, out_hport=4'd3, out_htrans=0, out_hmastlock=0, out_rsp_valid=0, out_rsp_data=0, out_rsp_err=0, out_req_ready=0 while in_rst=1.
- Acceptance on edge E0. Cycle 1 is ADDR; the responder samples at E1. Cycle 2 is DATA, with in_hrdata valid. Cycle 3 has out_rsp_valid=1.
- Latency: 3 cycles with zero wait states. Throughput: 1 read per 3 cycles.
- Each wait cycle (in_hready=0) in ADDR or DATA adds 1 cycle of latency.
- Reset during any state: return to IDLE on that edge. No response is emitted for the aborted transfer. Bus outputs take their reset values.
- All outputs are registered except out_req_ready.

## Configuration
- SWITCH_MCU_AHB_READ_MASTER_TIMEOUT_EN defined: a cycle counter clears on entry to DATA and counts in DATA and ERR. When TIMEOUT_CYCLES consecutive cycles pass with in_hready=0, the block goes to IDLE and emits rsp_valid=1, err=1, data=0 on the next cycle; out_htrans is already 0.
- Macro undefined: no counter; the block waits in DATA/ERR indefinitely.

## Test plan
- Zero-wait read: SRAM word 5 = 32'hCAFE_0005; request addr 32'h14 → htrans=1, haddr=32'h14 one cycle after accept; rsp_valid 3 cycles after accept, data=32'hCAFE_0005, err=0.
- Back-to-back: addrs 0x0, 0x4, 0x8 presented with valid held high → three responses 3 cycles apart, data matching words 0–2; htrans=1 for exactly one cycle each.
- Unaligned addr 32'h6 → no htrans pulse; rsp_valid next cycle with err=1, data=0.
- Error response: in DATA drive hready=0/hresp=1, then hready=1/hresp=1 → rsp err=1, data=0; next request proceeds normally.
- Wait states and reset: hold in_hready=0 for 4 cycles in ADDR → haddr and htrans stable, latency 7 cycles. Assert in_rst in DATA → no rsp_valid, all outputs at reset values.
- With macro, TIMEOUT_CYCLES=16: hold in_hready=0 in DATA → rsp err=1 exactly 16 cycles after DATA entry (+1 cycle for the pulse). Without macro: no response after 100 cycles.

Source files
------------

// File: rtl/switch_mcu_ahb_read_master.sv
// Single-outstanding AHB word-read initiator: 3-cycle latency, one request in flight, rsp pulse has no backpressure.
// Optional DATA/ERR wait timeout enabled by SWITCH_MCU_AHB_READ_MASTER_TIMEOUT_EN.
module switch_mcu_ahb_read_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_req_valid,
  input  logic [31:0] in_req_addr,
  output logic        out_req_ready,
  output logic        out_rsp_valid,
  output logic [31:0] out_rsp_data,
  output logic        out_rsp_err,
  output logic [31:0] out_haddr,
  output logic        out_hwrite,
  output logic [3:0]  out_hsize,
  output logic [2:0]  out_hburst,
  output logic [3:0]  out_hport,
  output logic [1:0]  out_htrans,
  output logic        out_hmastlock,
  input  logic        in_hready,
  input  logic        in_hresp,
  input  logic [31:0] in_hrdata
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;

  state_t      state, state_nxt;
  logic [31:0] haddr_nxt, rsp_data_nxt;
  logic [1:0]  htrans_nxt;
  logic        rsp_valid_nxt, rsp_err_nxt;
  logic        accept;
  logic        timeout;

  assign out_req_ready = (state == S_IDLE) && !in_rst;
  assign accept        = in_req_valid && out_req_ready;

  assign out_hwrite    = 1'b0;
  assign out_hsize     = 4'd2;
  assign out_hburst    = 3'd0;
  assign out_hport     = 4'd3;
  assign out_hmastlock = 1'b0;

`ifdef SWITCH_MCU_AHB_READ_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] to_cnt;

  // Held at zero outside DATA/ERR, so it restarts on every DATA entry.
  always_ff @(posedge in_clk) begin
    if (in_rst || !(state == S_DATA || state == S_ERR)) to_cnt <= '0;
    else                                                  to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = !in_hready && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    haddr_nxt     = out_haddr;
    htrans_nxt    = out_htrans;
    rsp_valid_nxt = 1'b0;
    rsp_data_nxt  = out_rsp_data;
    rsp_err_nxt   = out_rsp_err;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (in_req_addr[1:0] == 2'b00) begin
            haddr_nxt  = in_req_addr;
            htrans_nxt = 2'd1;
            state_nxt  = S_ADDR;
          end else begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_data_nxt  = '0;
          end
        end
      end
      S_ADDR: begin
        if (in_hready) begin
          htrans_nxt = 2'd0;
          state_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        if (in_hready) begin
          state_nxt     = S_IDLE;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = in_hresp;
          rsp_data_nxt  = in_hresp ? 32'd0 : in_hrdata;
        end else if (timeout) begin
          state_nxt     = S_IDLE;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_data_nxt  = '0;
        end else if (in_hresp) begin
          state_nxt = S_ERR;
        end
      end
      S_ERR: begin
        if (in_hready || timeout) begin
          state_nxt     = S_IDLE;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_data_nxt  = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state         <= S_IDLE;
      out_haddr     <= '0;
      out_htrans    <= 2'd0;
      out_rsp_valid <= 1'b0;
      out_rsp_data  <= '0;
      out_rsp_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      out_haddr     <= haddr_nxt;
      out_htrans    <= htrans_nxt;
      out_rsp_valid <= rsp_valid_nxt;
      out_rsp_data  <= rsp_data_nxt;
      out_rsp_err   <= rsp_err_nxt;
    end
  end

endmodule

// File: tb/tb_switch_mcu_ahb_read_master.sv
// Directed bench for switch_mcu_ahb_read_master with a small SRAM-like responder (word i = 32'hCAFE_0000 | i).
module tb_switch_mcu_ahb_read_master;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_req_valid;
  logic [31:0] in_req_addr;
  logic        out_req_ready;
  logic        out_rsp_valid;
  logic [31:0] out_rsp_data;
  logic        out_rsp_err;
  logic [31:0] out_haddr;
  logic        out_hwrite;
  logic [3:0]  out_hsize;
  logic [2:0]  out_hburst;
  logic [3:0]  out_hport;
  logic [1:0]  out_htrans;
  logic        out_hmastlock;
  logic        in_hready;
  logic        in_hresp;
  logic [31:0] in_hrdata;

  int errors = 0;
  int checks = 0;

  switch_mcu_ahb_read_master #(.TIMEOUT_CYCLES(16)) dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_req_valid(in_req_valid), .in_req_addr(in_req_addr), .out_req_ready(out_req_ready),
    .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_err(out_rsp_err),
    .out_haddr(out_haddr), .out_hwrite(out_hwrite), .out_hsize(out_hsize),
    .out_hburst(out_hburst), .out_hport(out_hport), .out_htrans(out_htrans),
    .out_hmastlock(out_hmastlock), .in_hready(in_hready), .in_hresp(in_hresp),
    .in_hrdata(in_hrdata)
  );

  always #5 in_clk = ~in_clk;

  // Responder: latch the word index in the address phase, return its word in the data phase.
  logic [3:0] rd_idx;
  always_ff @(posedge in_clk) begin
    if (in_rst)                               rd_idx <= '0;
    else if (out_htrans == 2'd1 && in_hready) rd_idx <= out_haddr[5:2];
  end
  assign in_hrdata = 32'hCAFE_0000 | {28'd0, rd_idx};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic issue(input logic [31:0] a);
    in_req_valid = 1'b1;
    in_req_addr  = a;
    @(negedge in_clk);
    in_req_valid = 1'b0;
  endtask

  // Cycles since acceptance until rsp_valid is seen; -1 if the bound expires.
  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (!out_rsp_valid && lat < start + 200) begin
      @(negedge in_clk);
      lat++;
    end
    if (!out_rsp_valid) lat = -1;
  endtask

  int         lat;
  int         idx, nrsp, ht, seen;
  logic       acc;
  int         rsp_c [3];
  logic [31:0] rsp_d [3];

  initial begin
    in_rst = 1'b1; in_req_valid = 1'b0; in_req_addr = '0; in_hready = 1'b1; in_hresp = 1'b0;
    for (int k = 0; k < 3; k++) begin rsp_c[k] = -1; rsp_d[k] = '0; end
    repeat (2) @(negedge in_clk);

    // Reset state
    chk("rst_req_ready", 32'(out_req_ready), 0);
    chk("rst_rsp_valid", 32'(out_rsp_valid), 0);
    chk("rst_haddr", out_haddr, 0);
    chk("rst_htrans", 32'(out_htrans), 0);
    chk("rst_hsize", 32'(out_hsize), 2);
    chk("rst_hport", 32'(out_hport), 3);
    chk("rst_hburst", 32'(out_hburst), 0);
    chk("rst_hwrite", 32'(out_hwrite), 0);
    chk("rst_hmastlock", 32'(out_hmastlock), 0);
    chk("rst_rsp_data", out_rsp_data, 0);
    chk("rst_rsp_err", 32'(out_rsp_err), 0);
    in_rst = 1'b0;
    @(negedge in_clk);
    chk("idle_req_ready", 32'(out_req_ready), 1);

    // Zero-wait read of word 5
    issue(32'h14);
    chk("zw_htrans", 32'(out_htrans), 1);
    chk("zw_haddr", out_haddr, 32'h14);
    chk("zw_busy_ready", 32'(out_req_ready), 0);
    wait_rsp(1, lat);
    chk("zw_latency", 32'(lat), 3);
    chk("zw_data", out_rsp_data, 32'hCAFE_0005);
    chk("zw_err", 32'(out_rsp_err), 0);
    chk("zw_ready_with_rsp", 32'(out_req_ready), 1);
    @(negedge in_clk);

    // Back-to-back with valid held high
    idx = 0; nrsp = 0; ht = 0;
    in_req_valid = 1'b1; in_req_addr = 32'h0;
    for (int c = 0; c < 12; c++) begin
      acc = out_req_ready && in_req_valid;
      @(negedge in_clk);
      if (acc) begin
        idx++;
        if (idx < 3) in_req_addr = 32'(idx * 4);
        else         in_req_valid = 1'b0;
      end
      if (out_htrans == 2'd1) ht++;
      if (out_rsp_valid && nrsp < 3) begin rsp_c[nrsp] = c; rsp_d[nrsp] = out_rsp_data; nrsp++; end
    end
    chk("b2b_nrsp", 32'(nrsp), 3);
    chk("b2b_htrans_cycles", 32'(ht), 3);
    chk("b2b_t0", 32'(rsp_c[0]), 2);
    chk("b2b_t1", 32'(rsp_c[1]), 5);
    chk("b2b_t2", 32'(rsp_c[2]), 8);
    chk("b2b_d0", rsp_d[0], 32'hCAFE_0000);
    chk("b2b_d1", rsp_d[1], 32'hCAFE_0001);
    chk("b2b_d2", rsp_d[2], 32'hCAFE_0002);

    // Unaligned request: immediate error, no bus access
    issue(32'h6);
    chk("ua_rsp_valid", 32'(out_rsp_valid), 1);
    chk("ua_err", 32'(out_rsp_err), 1);
    chk("ua_data", out_rsp_data, 0);
    chk("ua_htrans", 32'(out_htrans), 0);
    chk("ua_haddr", out_haddr, 32'h8);
    @(negedge in_clk);
    chk("ua_pulse_one", 32'(out_rsp_valid), 0);

    // Two-cycle error response through ERR
    issue(32'h8);
    @(negedge in_clk);
    in_hready = 1'b0; in_hresp = 1'b1;
    @(negedge in_clk);
    chk("err2_no_rsp_yet", 32'(out_rsp_valid), 0);
    in_hready = 1'b1;
    @(negedge in_clk);
    in_hresp = 1'b0;
    chk("err2_rsp_valid", 32'(out_rsp_valid), 1);
    chk("err2_err", 32'(out_rsp_err), 1);
    chk("err2_data", out_rsp_data, 0);

    issue(32'h4);
    wait_rsp(1, lat);
    chk("post_err_latency", 32'(lat), 3);
    chk("post_err_data", out_rsp_data, 32'hCAFE_0001);
    chk("post_err_err", 32'(out_rsp_err), 0);
    @(negedge in_clk);

    // Error with hready=1 in DATA
    issue(32'hC);
    @(negedge in_clk);
    in_hresp = 1'b1;
    @(negedge in_clk);
    in_hresp = 1'b0;
    chk("err1_rsp_valid", 32'(out_rsp_valid), 1);
    chk("err1_err", 32'(out_rsp_err), 1);
    chk("err1_data", out_rsp_data, 0);
    @(negedge in_clk);

    // Four wait states in ADDR
    issue(32'h20);
    in_hready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("ws_htrans", 32'(out_htrans), 1);
      chk("ws_haddr", out_haddr, 32'h20);
      @(negedge in_clk);
    end
    in_hready = 1'b1;
    chk("ws_htrans_last", 32'(out_htrans), 1);
    wait_rsp(5, lat);
    chk("ws_latency", 32'(lat), 7);
    chk("ws_data", out_rsp_data, 32'hCAFE_0008);
    @(negedge in_clk);

    // Reset while in DATA
    issue(32'h10);
    @(negedge in_clk);
    chk("rd_in_data_htrans", 32'(out_htrans), 0);
    in_hready = 1'b0; in_rst = 1'b1;
    @(negedge in_clk);
    chk("rd_rsp_valid", 32'(out_rsp_valid), 0);
    chk("rd_haddr", out_haddr, 0);
    chk("rd_htrans", 32'(out_htrans), 0);
    chk("rd_req_ready", 32'(out_req_ready), 0);
    chk("rd_rsp_data", out_rsp_data, 0);
    in_rst = 1'b0; in_hready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge in_clk);
      if (out_rsp_valid) seen++;
    end
    chk("rd_no_rsp", 32'(seen), 0);
    chk("rd_ready_after", 32'(out_req_ready), 1);

    // Stall in DATA
    issue(32'h18);
    @(negedge in_clk);
    in_hready = 1'b0;
`ifdef SWITCH_MCU_AHB_READ_MASTER_TIMEOUT_EN
    wait_rsp(2, lat);
    chk("to_latency", 32'(lat), 18);
    chk("to_err", 32'(out_rsp_err), 1);
    chk("to_data", out_rsp_data, 0);
    in_hready = 1'b1;
    @(negedge in_clk);
`else
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge in_clk);
      if (out_rsp_valid) seen++;
    end
    chk("stall_no_rsp", 32'(seen), 0);
    in_hready = 1'b1;
    wait_rsp(0, lat);
    chk("stall_rsp_seen", 32'(out_rsp_valid), 1);
    chk("stall_data", out_rsp_data, 32'hCAFE_0006);
    chk("stall_err", 32'(out_rsp_err), 0);
    @(negedge in_clk);
`endif

    issue(32'h1C);
    wait_rsp(1, lat);
    chk("final_latency", 32'(lat), 3);
    chk("final_data", out_rsp_data, 32'hCAFE_0007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
